// File: rtl/dco_counter.sv
// Digitally controlled oscillator built from a half-period counter.
// The loop-filter code retunes the half-period only at output toggles.
module dco_counter #(
  parameter int                   DCO_CC_WIDTH = 5,
  parameter int                   CNT_WIDTH    = 8,
  parameter logic [CNT_WIDTH-1:0] CENTRE_HP    = 8'd50,
  parameter logic [CNT_WIDTH-1:0] MIN_HP       = 8'd4,
  parameter logic [CNT_WIDTH-1:0] MAX_HP       = 8'd200
) (
  input  logic                           gen_clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
  output logic                           dco_clk_o,
  output logic                           dco_rise_o,
  output logic        [CNT_WIDTH-1:0]    half_period_o,
  output logic                           sat_o
);

  localparam int TW = CNT_WIDTH + 2;

  localparam logic signed [TW-1:0] CENTRE_S = {2'b00, CENTRE_HP};
  localparam logic signed [TW-1:0] MIN_S    = {2'b00, MIN_HP};
  localparam logic signed [TW-1:0] MAX_S    = {2'b00, MAX_HP};
  localparam logic [CNT_WIDTH-1:0] ONE      = 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hp_q, hp_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 sat_q, sat_d;

  logic signed [TW-1:0]  cc_ext;
  logic signed [TW-1:0]  target;
  logic [CNT_WIDTH-1:0]  hp_new;
  logic                  sat_new;
  logic                  tc;

  // Two extra bits keep CENTRE_HP - code from wrapping before the clamp.
  always_comb begin
    cc_ext  = TW'(dco_cc_i);
    target  = CENTRE_S - cc_ext;
    hp_new  = target[CNT_WIDTH-1:0];
    sat_new = 1'b0;
    if (target < MIN_S) begin
      hp_new  = MIN_HP;
      sat_new = 1'b1;
    end else if (target > MAX_S) begin
      hp_new  = MAX_HP;
      sat_new = 1'b1;
    end
  end

  assign tc = (cnt_q == hp_q - ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (enable_i) begin
          state_d = RUN;
          hp_d    = hp_new;
          sat_d   = sat_new;
        end
      end
      RUN: begin
        if (!tc) begin
          cnt_d = cnt_q + ONE;
        end else if (enable_i) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          rise_d = ~clk_q;
          hp_d   = hp_new;
          sat_d  = sat_new;
        end else begin
          cnt_d   = '0;
          clk_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= CENTRE_HP;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      sat_q   <= sat_d;
    end
  end

  assign dco_clk_o     = clk_q;
  assign dco_rise_o    = rise_q;
  assign half_period_o = hp_q;
  assign sat_o         = sat_q;

endmodule

// File: tb/tb_dco_counter.sv
// Directed bench for dco_counter: timing, retune, clamp, enable, reset.
// Three instances cover the default centre, a low centre and a high centre.
module tb_dco_counter;

  logic              clk = 1'b0;
  logic              reset;
  logic              en0, en1, en2;
  logic signed [4:0] cc0, cc1;

  logic       dclk0, rise0, sat0;
  logic [7:0] hp0;
  logic       dclk1, rise1, sat1;
  logic [7:0] hp1;
  logic       dclk2, rise2, sat2;
  logic [7:0] hp2;

  int checks = 0;
  int errors = 0;
  int n, r;

  always #5 clk = ~clk;

  dco_counter u0 (
    .gen_clk_i    (clk),
    .reset_i      (reset),
    .enable_i     (en0),
    .dco_cc_i     (cc0),
    .dco_clk_o    (dclk0),
    .dco_rise_o   (rise0),
    .half_period_o(hp0),
    .sat_o        (sat0)
  );

  dco_counter #(.CENTRE_HP(8'd10)) u1 (
    .gen_clk_i    (clk),
    .reset_i      (reset),
    .enable_i     (en1),
    .dco_cc_i     (cc1),
    .dco_clk_o    (dclk1),
    .dco_rise_o   (rise1),
    .half_period_o(hp1),
    .sat_o        (sat1)
  );

  dco_counter #(.CENTRE_HP(8'd195)) u2 (
    .gen_clk_i    (clk),
    .reset_i      (reset),
    .enable_i     (en2),
    .dco_cc_i     (cc1),
    .dco_clk_o    (dclk2),
    .dco_rise_o   (rise2),
    .half_period_o(hp2),
    .sat_o        (sat2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Count cycles until the selected oscillator reads lvl, and rises seen.
  task automatic wait_clk(input int sel, input logic lvl,
                          output int cyc, output int rises);
    logic c;
    cyc   = 0;
    rises = 0;
    do begin
      tick();
      cyc++;
      if ((sel == 0) ? rise0 : rise1) rises++;
      c = (sel == 0) ? dclk0 : dclk1;
    end while (c !== lvl && cyc < 1000);
  endtask

  initial begin
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    cc0 = 5'sd0; cc1 = 5'sd0;
    tick();
    tick();
    chk("rst_hp", hp0, 50);
    chk("rst_clk", dclk0, 0);
    chk("rst_rise", rise0, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_hp_u1", hp1, 10);

    reset = 1'b0;
    en0   = 1'b1;
    tick();
    chk("run_hp", hp0, 50);
    chk("run_clk", dclk0, 0);
    wait_clk(0, 1'b1, n, r);
    chk("first_rise", n, 50);
    chk("first_rise_cnt", r, 1);
    wait_clk(0, 1'b0, n, r);
    chk("high_len", n, 50);
    chk("high_rises", r, 0);
    chk("sat_cc0", sat0, 0);

    for (int i = 0; i < 10; i++) tick();
    cc0 = 5'sd10;
    wait_clk(0, 1'b1, n, r);
    chk("low_len_keep", n + 10, 50);
    chk("hp_cc10", hp0, 40);
    cc0 = -5'sd16;
    wait_clk(0, 1'b0, n, r);
    chk("high_40", n, 40);
    chk("hp_ccm16", hp0, 66);
    cc0 = 5'sd15;
    wait_clk(0, 1'b1, n, r);
    chk("low_66", n, 66);
    chk("hp_cc15", hp0, 35);
    chk("sat_cc15", sat0, 0);

    for (int i = 0; i < 5; i++) tick();
    en0 = 1'b0;
    wait_clk(0, 1'b0, n, r);
    chk("dis_high_len", n + 5, 35);
    r = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rise0 || dclk0) r++;
    end
    chk("idle_quiet", r, 0);

    cc0 = 5'sd10;
    en0 = 1'b1;
    tick();
    chk("reen_hp", hp0, 40);
    wait_clk(0, 1'b1, n, r);
    chk("reen_rise", n, 40);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cc0   = 5'sd0;
    chk("mid_rst_clk", dclk0, 0);
    chk("mid_rst_rise", rise0, 0);
    chk("mid_rst_hp", hp0, 50);
    tick();
    chk("rst_reen_hp", hp0, 50);
    wait_clk(0, 1'b1, n, r);
    chk("rst_reen_rise", n, 50);
    chk("rst_reen_rcnt", r, 1);

    cc1 = 5'sd15;
    en1 = 1'b1;
    tick();
    chk("clamp_lo_hp", hp1, 4);
    chk("clamp_lo_sat", sat1, 1);
    wait_clk(1, 1'b1, n, r);
    chk("clamp_lo_rise", n, 4);
    cc1 = 5'sd0;
    wait_clk(1, 1'b0, n, r);
    chk("clamp_lo_high", n, 4);
    chk("unclamp_hp", hp1, 10);
    chk("unclamp_sat", sat1, 0);
    wait_clk(1, 1'b1, n, r);
    chk("unclamp_low", n, 10);

    cc1 = -5'sd16;
    en2 = 1'b1;
    tick();
    chk("clamp_hi_hp", hp2, 200);
    chk("clamp_hi_sat", sat2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dco_counter.md
DCO_COUNTER -- requirements
Module: dco_counter

Interface
REQ-001 SHALL have parameter DCO_CC_WIDTH, default 5, meaning the width of the signed control code from the loop filter.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning the width of the half-period counter and register.
REQ-003 SHALL have parameter CENTRE_HP, default 8'd50, meaning the free-running half-period in gen_clk_i cycles at dco_cc_i = 0.
REQ-004 SHALL have parameter MIN_HP, default 8'd4, meaning the lower clamp on the half-period; it SHALL be at least 2.
REQ-005 SHALL have parameter MAX_HP, default 8'd200, meaning the upper clamp on the half-period.
REQ-006 SHALL have port gen_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port enable_i, input, 1 bit: oscillator run request.
REQ-009 SHALL have port dco_cc_i, input, signed DCO_CC_WIDTH bits: control code from the loop filter output register.
REQ-010 SHALL have port dco_clk_o, registered output, 1 bit: the oscillator output.
REQ-011 SHALL have port dco_rise_o, registered output, 1 bit: one-cycle pulse coincident with each 0->1 transition of dco_clk_o.
REQ-012 SHALL have port half_period_o, registered output, CNT_WIDTH bits: the half-period currently applied.
REQ-013 SHALL have port sat_o, registered output, 1 bit: the applied half-period was clamped.

Function
REQ-014 SHALL compute the target as CENTRE_HP minus the sign-extended dco_cc_i, in CNT_WIDTH+2 signed bits with no wrap; positive code means a shorter period.
REQ-015 SHALL clamp the target to [MIN_HP, MAX_HP]; sat_o is loaded with 1 whenever clamping occurred, at the same edge that loads half_period_o.
REQ-016 SHALL implement two states. IDLE: counter 0, dco_clk_o 0, dco_rise_o 0. RUN: the oscillator runs.
REQ-017 In IDLE with enable_i=1, SHALL move to RUN on the next edge, loading half_period_o/sat_o from the current dco_cc_i and clearing the counter.
REQ-018 In RUN, SHALL increment the counter each cycle; the terminal count is counter == half_period_o - 1.
REQ-019 At terminal count with enable_i=1, SHALL clear the counter, toggle dco_clk_o, and load half_period_o/sat_o from dco_cc_i sampled in that cycle.
REQ-020 SHALL ignore dco_cc_i in all other RUN cycles; changes take effect only at the next toggle, so no half-period is shortened or extended mid-phase.
REQ-021 SHALL assert dco_rise_o exactly in the cycle where dco_clk_o first reads 1; it SHALL be 0 otherwise.
REQ-022 At terminal count with enable_i=0 and dco_clk_o=1, SHALL drive dco_clk_o to 0 and go to IDLE.
REQ-023 At terminal count with enable_i=0 and dco_clk_o=0, SHALL go to IDLE with no toggle.
REQ-024 Dropping enable_i at a non-terminal cycle SHALL NOT truncate the current phase.
REQ-025 SHALL give an output period of exactly 2 x half_period_o cycles when the code is constant.
REQ-026 The first rising edge SHALL occur half_period_o cycles after RUN is entered.

Reset
REQ-027 reset_i=1 at a clock edge SHALL force, for the next cycle, all of the following, overriding all other inputs:
- state IDLE
- counter 0
- dco_clk_o 0
- dco_rise_o 0
- half_period_o = CENTRE_HP
- sat_o 0
REQ-028 Reset asserted mid-phase SHALL abort the phase with no extra rise pulse.

Verification
REQ-029 Defaults, cc=0, enable_i=1 after reset -> half_period_o=50, first dco_rise_o 50 cycles after RUN entry, then period 100, 50 high / 50 low, sat_o=0.
REQ-030 cc steps 0 -> +10 mid-low-phase -> current phase stays 50; the next phase is 40 (period 80); cc=-16 -> half_period_o=66; cc=+15 -> 35.
REQ-031 CENTRE_HP=10, cc=+15 -> target -5 clamped: half_period_o=4, sat_o=1; return to cc=0 -> 10, sat_o=0 at the next toggle.
REQ-032 enable_i dropped 5 cycles into a high phase -> high phase completes at full length, dco_clk_o falls, IDLE, and no further dco_rise_o.
REQ-033 reset_i pulsed 1 cycle mid-high-phase -> next cycle dco_clk_o=0, half_period_o=50, counter 0; with enable_i held high, RUN re-entered the following cycle.
